// File: rtl/embedded_computer_system_onchip_memory_pipe.sv
// On-chip RAM Avalon-MM slave with configurable width, depth and read latency.
// After reset the memory is swept to CLEAR_VALUE before any request is accepted,
// so software always starts from a defined memory image.
// Legal READ_LATENCY values are 1 and 2; DEPTH must not exceed 2**ADDR_WIDTH.
module embedded_computer_system_onchip_memory_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int DEPTH          = 32768,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    localparam int NumLanes = DATA_WIDTH / 8;
    localparam int IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DepthL   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        StClear,
        StReady
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clrCnt_q, clrCnt_d;

    logic                    en;
    logic                    inRange;
    logic                    acceptRead;
    logic                    acceptWrite;
    logic [DATA_WIDTH-1:0]   rawRead;

    logic                    memWe;
    logic [IdxWidth-1:0]     memIdx;
    logic [DATA_WIDTH-1:0]   memWdata;
    logic [NumLanes-1:0]     memBe;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    rdValid1_q;
    logic [DATA_WIDTH-1:0]   rdData1_q;

    // A reset request is treated exactly like a dropped clock enable, so both
    // freeze every piece of state and stall the bus through waitrequest.
    assign en          = clken & ~reset_req;
    assign waitrequest = (state_q != StReady) | ~en;
    assign init_done   = (state_q == StReady);

    // Out-of-range accesses are filtered here: writes are dropped and reads
    // return zero, while still producing a normal readdatavalid pulse.
    assign inRange     = ({1'b0, address} < DepthL);
    assign acceptWrite = chipselect & write & ~waitrequest;
    assign acceptRead  = chipselect & read & ~write & ~waitrequest;
    assign rawRead     = inRange ? mem_q[address[IdxWidth-1:0]] : '0;

    // State register and clear counter; reset always restarts the sweep at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StClear;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    // Next-state logic, which also steers the single RAM write port between the
    // clear sweep and bus writes so there is only ever one writer.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        memWe    = 1'b0;
        memIdx   = address[IdxWidth-1:0];
        memWdata = writedata;
        memBe    = byteenable;
        case (state_q)
            StClear: begin
                if (en) begin
                    if (CLEAR_ON_RESET != 0) begin
                        memWe    = 1'b1;
                        memIdx   = clrCnt_q[IdxWidth-1:0];
                        memWdata = CLEAR_VALUE;
                        memBe    = '1;
                        if (clrCnt_q == LastAddr) begin
                            state_d = StReady;
                        end else begin
                            clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                if (acceptWrite && inRange) begin
                    memWe = 1'b1;
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // RAM array with per-byte write lanes; left without reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (memBe[i]) begin
                    mem_q[memIdx][i*8 +: 8] <= memWdata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: captures RAM output only on accepted reads so the data
    // holds its value between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid1_q <= 1'b0;
            rdData1_q  <= '0;
        end else if (en) begin
            rdValid1_q <= acceptRead;
            if (acceptRead) begin
                rdData1_q <= rawRead;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : gLat2
            logic                  rdValid2_q;
            logic [DATA_WIDTH-1:0] rdData2_q;

            // Optional output register stage, advancing only on enabled edges.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdValid2_q <= 1'b0;
                    rdData2_q  <= '0;
                end else if (en) begin
                    rdValid2_q <= rdValid1_q;
                    if (rdValid1_q) begin
                        rdData2_q <= rdData1_q;
                    end
                end
            end

            assign readdata      = rdData2_q;
            assign readdatavalid = rdValid2_q;
        end else begin : gLat1
            assign readdata      = rdData1_q;
            assign readdatavalid = rdValid1_q;
        end
    endgenerate

endmodule

// File: doc/embedded_computer_system_onchip_memory_pipe.md
# embedded_computer_system_onchip_memory_pipe

Parametrised on-chip RAM Avalon-MM slave; successor to the fixed 32x32768 single-port RAM in the embedded computer system. It adds:
- configurable width, depth and read latency;
- explicit `read`, `readdatavalid` and `waitrequest` handshakes;
- a hardware clear sweep after reset, so software sees a defined memory image.

It sits on the Nios data/instruction interconnect in place of the fixed RAM.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 15: word-address width.
- `DEPTH`, 32768: number of words; ≤ 2**ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 = RAM output direct; 2 = extra output register. Other values are illegal.
- `CLEAR_ON_RESET`, 1: 1 = sweep memory after reset; 0 = skip the sweep.
- `CLEAR_VALUE`, 0: word written during the sweep.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `reset_req` in 1: reset-request hint; while high, the block behaves as if `clken`=0.
- `clken` in 1: clock enable.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `address` in ADDR_WIDTH: word address.
- `byteenable` in DATA_WIDTH/8: write byte lanes.
- `writedata` in DATA_WIDTH: write data.
- `readdata` out DATA_WIDTH: read data.
- `readdatavalid` out 1: `readdata` valid this cycle.
- `waitrequest` out 1: request not accepted this cycle.
- `init_done` out 1: clear sweep finished.

## Operation
**Enable**
- `en = clken & ~reset_req`.
- When `en`=0, all state holds: FSM, clear counter, RAM, read pipeline and `readdatavalid`.

**FSM**
- States: CLEAR, READY.
- Reset enters CLEAR with the clear counter at 0.
- CLEAR, when `en`=1:
  - Write `CLEAR_VALUE` with all byte lanes enabled at the counter address, then increment the counter.
  - After writing address DEPTH-1, go to READY.
- If `CLEAR_ON_RESET`=0: CLEAR performs no write and exits to READY on the first enabled edge.
- READY is terminal until `reset`.
- `reset` asserted mid-sweep: aborts the sweep; the sweep restarts at 0 after release.

**Handshake**
- `waitrequest = (state != READY) | ~en`. This is combinational on `clken`/`reset_req`.
- Accept = `chipselect & (read | write) & ~waitrequest`.
- Accepted write: bytes with `byteenable[i]`=1 are written; other bytes are unchanged.
- Accepted read: data is returned per Timing.
- `read` and `write` both high: the write executes and the read is dropped (no `readdatavalid`).
- `address` ≥ DEPTH:
  - a write is discarded;
  - a read returns all zeros with normal `readdatavalid` timing.
- `readdata` holds its last value while `readdatavalid`=0.

## Timing
**Reset values**
- `readdata`=0, `readdatavalid`=0, `init_done`=0.
- `waitrequest`=1.

**Clear sweep**
- CLEAR_ON_RESET=1: takes exactly DEPTH enabled cycles.
- `init_done` and READY rise together on the edge after the last clear write.
- `waitrequest` falls in that same cycle, provided `en`=1.

**Reads**
- `readdatavalid` pulses for exactly one cycle, READ_LATENCY enabled edges after the accepting edge.
- Back-to-back reads, one per cycle, return in order with no bubbles.
- Pipeline state advances only on enabled edges. A read in flight while `en` drops completes READ_LATENCY enabled edges after acceptance.

**Writes**
- A write is visible to a read accepted on the next cycle: read-after-write to the same address returns the new data.

**Reset during a read**
- `reset` asserted with a read in flight: the pending `readdatavalid` is cancelled.

## Test plan
1. **Clear sweep.** Params DEPTH=16, CLEAR_ON_RESET=1, CLEAR_VALUE=32'hDEADBEEF; release reset.
   - Required: `waitrequest`=1 for 16 cycles, then `init_done`=1.
   - Required: reads of addresses 0..15 all return 32'hDEADBEEF.
2. **Byte-enable write.** Write 32'h11223344 to addr 5, then write 32'hAABBCCDD with `byteenable`=4'b0101.
   - Required: a read of addr 5 returns 32'h11BB33DD.
3. **Read latency 2.** Params READ_LATENCY=2; accept reads of addr 1, 2, 3 on consecutive cycles.
   - Required: `readdatavalid` high on cycles +2, +3, +4 with the matching data, and low otherwise.
4. **Stall.** Drop `clken` for 3 cycles with one read in flight.
   - Required: `waitrequest`=1 during the stall.
   - Required: `readdatavalid` is delayed by exactly 3 cycles with correct data.
   - Required: an asserted `reset_req` behaves identically.
5. **Out-of-range and read+write collision.** Params DEPTH=10.
   - Write 32'h55 to addr 12; read addr 12. Required: returns 0.
   - Simultaneous read+write to addr 3. Required: the write lands and no `readdatavalid` is produced.
6. **Reset mid-operation.** Assert `reset` at clear count 7 with a read pending.
   - Required: all outputs go to reset values immediately.
   - Required: after release, the sweep restarts from address 0 and takes the full DEPTH cycles.
